// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and command decode for the control sequencer
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXECUTE,
    ST_MEM_WAIT,
    ST_STORE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_NOP,
    CLS_READ,
    CLS_WRITE
  } cmd_class_e;

  // Only the two low opcode bits select the memory operation; wider opcodes alias.
  function automatic cmd_class_e decode_class(input logic cls, input logic [1:0] op_lo);
    cmd_class_e c;
    if (!cls) begin
      c = CLS_ALU;
    end else begin
      case (op_lo)
        2'b01:   c = CLS_READ;
        2'b10:   c = CLS_WRITE;
        default: c = CLS_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// rtl/ctrl_mem_timer.sv - memory wait-state counter with timeout compare
module ctrl_mem_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  // Holds at the limit so a stray enable after expiry cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle control FSM for the nbits CPU datapath
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int OP_W     = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16,
  localparam int CMD_W   = 2*SEL_W + OP_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             p_error,
  input  logic             mem_ack,
  output logic             cmd_ready,
  output logic             datain_reg_en,
  output logic             aluin_reg_en,
  output logic             aluout_reg_en,
  output logic             mem_write,
  output logic             mem_read,
  output logic             selmux2,
  output logic             invalid_data,
  output logic [SEL_W-1:0] in_select_a,
  output logic [SEL_W-1:0] in_select_b,
  output logic [OP_W-1:0]  opcode,
  output logic             busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e           state_q, state_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             cls;
  logic [OP_W-1:0]  op;
  cmd_class_e       cmd_class;
  logic             timer_en, timer_expired, to_store;

  assign sel_a     = cmd_in[CMD_W-1 -: SEL_W];
  assign sel_b     = cmd_in[OP_W+1 +: SEL_W];
  assign cls       = cmd_in[OP_W];
  assign op        = cmd_in[OP_W-1:0];
  assign cmd_class = decode_class(cls, op[1:0]);

  assign mem_timeout = mem_timeout_q;
  assign retired_cnt = retired_q;

  ctrl_mem_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_FETCH),
    .en     (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    mem_timeout_d = mem_timeout_q;
    retired_d     = retired_q;
    to_store      = 1'b0;
    timer_en      = 1'b0;
    cmd_ready     = 1'b0;
    datain_reg_en = 1'b0;
    aluin_reg_en  = 1'b0;
    aluout_reg_en = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    selmux2       = 1'b0;
    invalid_data  = 1'b0;
    in_select_a   = '0;
    in_select_b   = '0;
    opcode        = '0;
    busy          = 1'b0;

    case (state_q)
      ST_INIT, ST_STORE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          datain_reg_en = 1'b1;
          mem_timeout_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy         = 1'b1;
        in_select_a  = sel_a;
        in_select_b  = sel_b;
        aluin_reg_en = (cmd_class != CLS_NOP);
        state_d      = ST_EXECUTE;
      end
      ST_EXECUTE, ST_MEM_WAIT: begin
        busy = 1'b1;
        case (cmd_class)
          CLS_ALU: begin
            opcode        = op;
            aluout_reg_en = 1'b1;
            // All-ones select is the external port, the only parity-checked source.
            invalid_data  = p_error & ((sel_a == '1) | (sel_b == '1));
            to_store      = 1'b1;
          end
          CLS_NOP: to_store = 1'b1;
          default: begin
            selmux2       = 1'b1;
            mem_read      = (cmd_class == CLS_READ);
            mem_write     = (cmd_class == CLS_WRITE);
            aluout_reg_en = (cmd_class == CLS_READ) & mem_ack;
            timer_en      = !mem_ack;
            if (mem_ack) begin
              to_store = 1'b1;
            end else if (timer_expired) begin
              to_store      = 1'b1;
              mem_timeout_d = 1'b1;
            end else begin
              state_d = ST_MEM_WAIT;
            end
          end
        endcase
      end
      default: state_d = ST_INIT;
    endcase

    if (to_store) begin
      state_d   = ST_STORE;
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      mem_timeout_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
      retired_q     <= retired_d;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;

  localparam int WAIT_MAX = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_EXEC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [6:0]  cmd_in;
  logic        p_error;
  logic        mem_ack;
  logic        cmd_ready, datain_reg_en, aluin_reg_en, aluout_reg_en;
  logic        mem_write, mem_read, selmux2, invalid_data, busy, mem_timeout;
  logic [1:0]  in_select_a, in_select_b, opcode;
  logic [15:0] retired_cnt;
  logic [15:0] obs;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] model_cnt = 0;
  logic        model_to  = 0;
  logic [15:0] ev;

  ctrl_sequencer #(.SEL_W(2), .OP_W(2), .WAIT_MAX(WAIT_MAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_in(cmd_in),
    .p_error(p_error), .mem_ack(mem_ack), .cmd_ready(cmd_ready),
    .datain_reg_en(datain_reg_en), .aluin_reg_en(aluin_reg_en),
    .aluout_reg_en(aluout_reg_en), .mem_write(mem_write), .mem_read(mem_read),
    .selmux2(selmux2), .invalid_data(invalid_data), .in_select_a(in_select_a),
    .in_select_b(in_select_b), .opcode(opcode), .busy(busy),
    .mem_timeout(mem_timeout), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {cmd_ready, datain_reg_en, aluin_reg_en, aluout_reg_en, mem_write,
                mem_read, selmux2, invalid_data, in_select_a, in_select_b, opcode,
                busy, mem_timeout};

  // Expected output bundle for one cycle of a command, derived from its class.
  function automatic logic [15:0] exp_vec(int ph, logic [6:0] c, logic v, logic a,
                                          logic pe, logic to);
    logic [15:0] r;
    logic [1:0]  sa, sb, op;
    logic        cl, is_nop, is_rd, is_wr;
    sa = c[6:5]; sb = c[4:3]; cl = c[2]; op = c[1:0];
    is_nop = cl && (op == 2'd0 || op == 2'd3);
    is_rd  = cl && op == 2'd1;
    is_wr  = cl && op == 2'd2;
    r = '0;
    if (ph == PH_IDLE) begin
      r[15] = 1'b1; r[14] = v; r[0] = to;
    end else if (ph == PH_FETCH) begin
      r[7:6] = sa; r[5:4] = sb; r[13] = !is_nop; r[1] = 1'b1;
    end else begin
      r[1] = 1'b1;
      if (!cl) begin
        r[3:2] = op; r[12] = 1'b1; r[8] = pe && (sa == 2'd3 || sb == 2'd3);
      end else if (is_rd || is_wr) begin
        r[9] = 1'b1; r[10] = is_rd; r[11] = is_wr; r[12] = is_rd && a;
      end
    end
    return r;
  endfunction

  // ack_at: request cycle (0-based) carrying mem_ack; -1 = never.
  task automatic do_cmd(input string nm, input logic [6:0] c, input int ack_at, input logic pe);
    logic mem_cls;
    mem_cls = c[2] && (c[1:0] == 2'd1 || c[1:0] == 2'd2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_in = c; mem_ack = 1'($urandom); p_error = 1'($urandom);
    #1;
    ev = exp_vec(PH_IDLE, c, 1'b1, 1'b0, 1'b0, model_to);
    n_cmp++;
    if (obs !== ev) begin n_fail++; $display("FAIL %s accept: got %h want %h", nm, obs, ev); end
    n_cmp++;
    if (retired_cnt !== model_cnt) begin
      n_fail++; $display("FAIL %s retired_cnt: got %0d want %0d", nm, retired_cnt, model_cnt);
    end
    model_to = 1'b0;
    @(negedge clk);
    cmd_valid = 1'($urandom); mem_ack = 1'($urandom); p_error = 1'($urandom);
    #1;
    ev = exp_vec(PH_FETCH, c, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (obs !== ev) begin n_fail++; $display("FAIL %s fetch: got %h want %h", nm, obs, ev); end
    if (!mem_cls) begin
      @(negedge clk);
      cmd_valid = 1'b0; mem_ack = 1'($urandom); p_error = pe;
      #1;
      ev = exp_vec(PH_EXEC, c, 1'b0, mem_ack, pe, 1'b0);
      n_cmp++;
      if (obs !== ev) begin n_fail++; $display("FAIL %s execute: got %h want %h", nm, obs, ev); end
    end else begin
      for (int k = 0; k <= WAIT_MAX; k++) begin
        @(negedge clk);
        cmd_valid = 1'b0; p_error = 1'($urandom); mem_ack = (k == ack_at);
        #1;
        ev = exp_vec(PH_EXEC, c, 1'b0, mem_ack, p_error, 1'b0);
        n_cmp++;
        if (obs !== ev) begin
          n_fail++; $display("FAIL %s mem cycle %0d: got %h want %h", nm, k, obs, ev);
        end
        if (mem_ack) break;
        if (k == WAIT_MAX) model_to = 1'b1;
      end
    end
    model_cnt++;
  endtask

  task automatic idle_cycle(input string nm);
    @(negedge clk);
    cmd_valid = 1'b0; mem_ack = 1'($urandom); p_error = 1'($urandom);
    #1;
    ev = exp_vec(PH_IDLE, 7'd0, 1'b0, 1'b0, 1'b0, model_to);
    n_cmp++;
    if (obs !== ev) begin n_fail++; $display("FAIL %s idle: got %h want %h", nm, obs, ev); end
    n_cmp++;
    if (retired_cnt !== model_cnt) begin
      n_fail++; $display("FAIL %s idle retired_cnt: got %0d want %0d", nm, retired_cnt, model_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_in = '0; p_error = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (obs !== 16'h8000) begin n_fail++; $display("FAIL reset outputs: got %h want 8000", obs); end
    n_cmp++;
    if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL reset retired_cnt: got %0d want 0", retired_cnt); end
    rst = 1'b0;
    idle_cycle("reset_hold");
  endtask

  task automatic test_alu();
    do_cmd("alu", 7'b01_10_0_11, -1, 1'b0);
    idle_cycle("alu_store");
    n_cmp++;
    if (retired_cnt !== 16'd1) begin n_fail++; $display("FAIL alu retired: got %0d want 1", retired_cnt); end
  endtask

  task automatic test_parity();
    do_cmd("parity_err", 7'b11_00_0_01, -1, 1'b1);
    do_cmd("parity_ok", 7'b11_00_0_01, -1, 1'b0);
    do_cmd("parity_b", 7'b00_11_0_10, -1, 1'b1);
  endtask

  task automatic test_memory();
    do_cmd("read_ack3", 7'b00_00_1_01, 2, 1'b0);
    do_cmd("write_timeout", 7'b00_00_1_10, -1, 1'b0);
    idle_cycle("timeout_hold");
    idle_cycle("timeout_hold2");
    do_cmd("read_zero_wait", 7'b00_00_1_01, 0, 1'b0);
    do_cmd("read_last_ack", 7'b10_01_1_01, WAIT_MAX, 1'b0);
    do_cmd("read_timeout", 7'b00_00_1_01, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_cmd("nop_11", 7'b00_00_1_11, -1, 1'b0);
    do_cmd("nop_00", 7'b00_00_1_00, -1, 1'b0);
    do_cmd("alu_b2b", 7'b11_11_0_00, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_cmd("pre_reset", 7'b01_01_0_01, -1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_in = 7'b00_00_1_01; mem_ack = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++;
      if (mem_read !== 1'b1) begin n_fail++; $display("FAIL mid mem_read before reset: got %b want 1", mem_read); end
    end
    #1;
    rst = 1'b1;
    #1;
    model_cnt = 0; model_to = 1'b0;
    n_cmp++;
    if (obs !== 16'h8000) begin n_fail++; $display("FAIL mid reset outputs: got %h want 8000", obs); end
    n_cmp++;
    if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL mid reset retired_cnt: got %0d want 0", retired_cnt); end
    @(negedge clk);
    rst = 1'b0;
    do_cmd("post_reset", 7'b00_00_1_01, 1, 1'b0);
    idle_cycle("post_reset_store");
  endtask

  task automatic test_random();
    logic [6:0] c;
    int         a;
    for (int i = 0; i < 40; i++) begin
      c = 7'($urandom);
      a = $urandom_range(0, WAIT_MAX + 2);
      if (a > WAIT_MAX) a = -1;
      do_cmd("random", c, a, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle("random_gap");
    end
    idle_cycle("random_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_parity();
    test_memory();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
